mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised, elastic MEM->WB pipeline stage for the yadan core.
- Carries LANES independent register-write channels (lanes), so one stage serves both single-issue and dual-issue builds.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the regfile/WB side never creates a combinational path back to MEM.
- Supports synchronous flush, x0-write suppression and same-beat write-conflict resolution.

Parameters:
- DATA_W, 32, width of write-back data per lane.
- ADDR_W, 5, width of the register address per lane.
- LANES, 1, number of write channels per beat; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all held beats.
- in_valid_i  in  1  MEM presents a beat.
- in_ready_o  out  1  stage can accept a beat.
- in_wreg_i  in  LANES  per-lane write enable.
- in_addr_i  in  LANES*ADDR_W  per-lane destination address; lane k occupies bits [k*ADDR_W +: ADDR_W].
- in_data_i  in  LANES*DATA_W  per-lane write data; same packing as in_addr_i.
- out_valid_o  out  1  WB beat valid.
- out_ready_i  in  1  regfile/WB accepts the beat.
- wb_wreg_o  out  LANES  per-lane regfile write strobe.
- wb_addr_o  out  LANES*ADDR_W  per-lane write address.
- wb_data_o  out  LANES*DATA_W  per-lane write data.
- retire_cnt_o  out  32  count of beats accepted downstream.

Behaviour:
- Reset (async, rst_n=0): main/skid valid=0, out_valid_o=0, wb_wreg_o=0, wb_addr_o=0, wb_data_o=0, retire_cnt_o=0, in_ready_o=1.
- Reset takes effect immediately, including mid-transfer; any held beats are lost.
- Storage: a main register (drives the outputs) and a skid register. Each holds {valid, wreg[LANES], addr, data}.
- in_ready_o = !skid_valid. It is registered state only and never depends combinationally on out_ready_i.
- Accept: in_valid_i & in_ready_o. Emit: out_valid_o & out_ready_i.
- Next-state rules, evaluated in this order:
  - flush_i=1: both valids cleared next cycle; the input beat is dropped even if it was accepted. Flush has priority over everything else except reset. retire_cnt_o still increments if an emit occurs in the same cycle.
  - Main empty, or emit this cycle: main loads the skid beat if skid is valid (skid clears), else the input beat if accepted.
  - Main full, no emit, accept: input goes into skid; in_ready_o drops next cycle.
  - Skid valid, emit, accept: not possible, since in_ready_o=0.
- Latency: 1 cycle from accept to out_valid_o when the stage is empty. Throughput: 1 beat/cycle while out_ready_i=1.
- Conditioning, applied on load into main (registered, not on the output path):
  - Lane wreg is forced to 0 when its addr==0 (x0 suppression).
  - If lanes i<j both write the same addr, lane i's wreg is cleared. The higher-index (younger) lane wins.
- wb_wreg_o = main.wreg gated by out_valid_o. Addr/data outputs are held unchanged while out_ready_i=0.
- retire_cnt_o increments by 1 on each emit and wraps at 2^32-1 -> 0.
- A beat with all wreg=0 is still a valid beat: it is emitted and counted.

Optional Feature:
- Macro: MEMWB_FWD_EN.
- Defined: adds ports fwd_addr_i (in, ADDR_W), fwd_hit_o (out, 1) and fwd_data_o (out, DATA_W). This is a combinational lookup for ID-stage forwarding.
  - Search order: skid lanes highest-index first, then main lanes highest-index first.
  - A lane matches if its valid is set, its conditioned wreg=1 and its addr==fwd_addr_i.
  - Youngest match wins.
  - fwd_addr_i==0 always gives fwd_hit_o=0 and fwd_data_o=0.
  - No match gives fwd_hit_o=0 and fwd_data_o=0.
- Undefined: these ports and the lookup logic are absent; all other behaviour is identical.

Decomposition:
- Package yadan_pipe_pkg holds the lane payload struct {wreg, addr, data} and the constants ZERO_ADDR and ZERO_WORD; the existing yadan_defs reset/enable constants are reused.
- One sub-module, wb_lane_cond: combinational x0 and conflict masking over LANES lanes. It is instantiated on the load path.

Test Plan:
- Reset/single beat: LANES=1, rst_n released, beat {1,5,0xDEADBEEF} with out_ready_i=1 -> next cycle out_valid_o=1, wb_wreg_o=1, addr 5, data 0xDEADBEEF; retire_cnt_o=1 one cycle later.
- Back-pressure: out_ready_i=0, beats A then B -> B lands in skid, in_ready_o=0, outputs hold A. Raise out_ready_i -> A then B emitted on consecutive cycles, in_ready_o=1 again.
- Flush with both entries full and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, the input beat is never emitted.
- LANES=2, both lanes write addr 7 (0x11, 0x22) -> wb_wreg_o=2'b10, lane1 data 0x22. Lane0 addr 0 with wreg=1 -> lane0 strobe 0.
- MEMWB_FWD_EN: main holds x3=0x10, skid holds x3=0x20, fwd_addr_i=3 -> fwd_hit_o=1, fwd_data_o=0x20. fwd_addr_i=0 -> hit 0.
- Counter wrap: force retire_cnt_o to 0xFFFFFFFF, one emit -> 0x00000000.

Source files
------------

// File: rtl/yadan_pipe_pkg.sv
// rtl/yadan_pipe_pkg.sv - shared lane payload type and constants for the yadan MEM->WB stage
package yadan_pipe_pkg;

  // Core-wide reset and write-enable levels
  localparam logic RST_ENABLE    = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  // Native register-file geometry of the core
  localparam int unsigned CORE_ADDR_W = 5;
  localparam int unsigned CORE_DATA_W = 32;

  localparam logic [CORE_ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [CORE_DATA_W-1:0] ZERO_WORD = '0;

  // One register-write channel as carried between MEM and WB
  typedef struct packed {
    logic                   wreg;
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] data;
  } lane_payload_t;

endpackage

// File: rtl/wb_lane_cond.sv
// rtl/wb_lane_cond.sv - x0 suppression and same-beat write-conflict masking across lanes
module wb_lane_cond
  import yadan_pipe_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
) (
  input  logic [LANES-1:0]        wreg_i,
  input  logic [LANES*ADDR_W-1:0] addr_i,
  output logic [LANES-1:0]        wreg_o
);

  // A lane keeps its strobe only if it targets a non-zero register that no younger lane also writes
  always_comb begin
    wreg_o = wreg_i;
    for (int i = 0; i < LANES; i++) begin
      if (addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_ADDR)) begin
        wreg_o[i] = WRITE_DISABLE;
      end
      for (int j = i + 1; j < LANES; j++) begin
        if (wreg_i[j] && (addr_i[j*ADDR_W +: ADDR_W] == addr_i[i*ADDR_W +: ADDR_W])) begin
          wreg_o[i] = WRITE_DISABLE;
        end
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - elastic multi-lane MEM->WB stage with skid buffer; optional MEMWB_FWD_EN forwarding lookup
module mem_wb_stage
  import yadan_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES-1:0]        in_wreg_i,
  input  logic [LANES*ADDR_W-1:0] in_addr_i,
  input  logic [LANES*DATA_W-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES-1:0]        wb_wreg_o,
  output logic [LANES*ADDR_W-1:0] wb_addr_o,
  output logic [LANES*DATA_W-1:0] wb_data_o,
  output logic [31:0]             retire_cnt_o
`ifdef MEMWB_FWD_EN
  , input  logic [ADDR_W-1:0]     fwd_addr_i
  , output logic                  fwd_hit_o
  , output logic [DATA_W-1:0]     fwd_data_o
`endif
);

  typedef struct packed {
    logic                    valid;
    logic [LANES-1:0]        wreg;
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES*DATA_W-1:0] data;
  } slot_t;

  slot_t            main_q, main_d;
  slot_t            skid_q, skid_d;
  slot_t            in_beat;
  logic [LANES-1:0] cond_wreg;
  logic [31:0]      retire_cnt_q;
  logic             accept;
  logic             emit;

  // Conditioning is done once at the input so both storage slots hold final strobes
  wb_lane_cond #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_lane_cond (
    .wreg_i (in_wreg_i),
    .addr_i (in_addr_i),
    .wreg_o (cond_wreg)
  );

  assign in_ready_o = !skid_q.valid;
  assign accept     = in_valid_i && in_ready_o;
  assign emit       = main_q.valid && out_ready_i;

  // Pack the conditioned incoming beat
  always_comb begin
    in_beat       = '0;
    in_beat.valid = 1'b1;
    in_beat.wreg  = cond_wreg;
    in_beat.addr  = in_addr_i;
    in_beat.data  = in_data_i;
  end

  // Slot next-state: flush wins, then refill main from skid or input, else spill input into skid
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (!main_q.valid || emit) begin
      if (skid_q.valid) begin
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = in_beat;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = in_beat;
    end
  end

  // Slot registers; payload bits of an emptied slot are kept so outputs stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Retired-beat counter counts every downstream handshake, flush or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      retire_cnt_q <= '0;
    end else if (emit) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign out_valid_o  = main_q.valid;
  assign wb_wreg_o    = main_q.wreg & {LANES{main_q.valid}};
  assign wb_addr_o    = main_q.addr;
  assign wb_data_o    = main_q.data;
  assign retire_cnt_o = retire_cnt_q;

`ifdef MEMWB_FWD_EN
  // Forwarding lookup: later assignments override, so skid beats main and higher lanes beat lower
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = DATA_W'(ZERO_WORD);
    if (fwd_addr_i != ADDR_W'(ZERO_ADDR)) begin
      for (int k = 0; k < LANES; k++) begin
        if (main_q.valid && main_q.wreg[k] && (main_q.addr[k*ADDR_W +: ADDR_W] == fwd_addr_i)) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = main_q.data[k*DATA_W +: DATA_W];
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if (skid_q.valid && skid_q.wreg[k] && (skid_q.addr[k*ADDR_W +: ADDR_W] == fwd_addr_i)) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = skid_q.data[k*DATA_W +: DATA_W];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized bench for mem_wb_stage against a queue-based reference model
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush_i = 1'b0;
  logic                    in_valid_i = 1'b0;
  logic                    in_ready_o;
  logic [LANES-1:0]        in_wreg_i = '0;
  logic [LANES*ADDR_W-1:0] in_addr_i = '0;
  logic [LANES*DATA_W-1:0] in_data_i = '0;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b0;
  logic [LANES-1:0]        wb_wreg_o;
  logic [LANES*ADDR_W-1:0] wb_addr_o;
  logic [LANES*DATA_W-1:0] wb_data_o;
  logic [31:0]             retire_cnt_o;
`ifdef MEMWB_FWD_EN
  logic [ADDR_W-1:0]       fwd_addr_i = '0;
  logic                    fwd_hit_o;
  logic [DATA_W-1:0]       fwd_data_o;
`endif

  mem_wb_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_wreg_i    (in_wreg_i),
    .in_addr_i    (in_addr_i),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .wb_wreg_o    (wb_wreg_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .retire_cnt_o (retire_cnt_o)
`ifdef MEMWB_FWD_EN
    , .fwd_addr_i (fwd_addr_i)
    , .fwd_hit_o  (fwd_hit_o)
    , .fwd_data_o (fwd_data_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0]        wreg;
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES*DATA_W-1:0] data;
  } beat_t;

  // Reference: the stage is a 2-deep FIFO; head is what WB sees
  beat_t       q[$];
  logic [31:0] m_cnt = '0;
  bit          check_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Younger lanes claim an address first; older lanes writing a claimed or zero address lose their strobe
  function automatic beat_t cond(input logic [LANES-1:0] w, input logic [LANES*ADDR_W-1:0] a,
                                 input logic [LANES*DATA_W-1:0] d);
    beat_t      b;
    logic [31:0] claimed;
    claimed = '0;
    b.wreg  = '0;
    b.addr  = a;
    b.data  = d;
    for (int i = LANES - 1; i >= 0; i--) begin
      int r;
      r = int'(a[i*ADDR_W +: ADDR_W]);
      if (w[i] && r != 0 && !claimed[r]) b.wreg[i] = 1'b1;
      if (w[i]) claimed[r] = 1'b1;
    end
    return b;
  endfunction

`ifdef MEMWB_FWD_EN
  function automatic logic [DATA_W:0] fwd_model(input logic [ADDR_W-1:0] fa);
    if (fa == '0) return '0;
    for (int e = q.size() - 1; e >= 0; e--)
      for (int k = LANES - 1; k >= 0; k--)
        if (q[e].wreg[k] && q[e].addr[k*ADDR_W +: ADDR_W] == fa)
          return {1'b1, q[e].data[k*DATA_W +: DATA_W]};
    return '0;
  endfunction
`endif

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", in_ready_o, q.size() < 2);
      chk("out_valid", out_valid_o, q.size() > 0);
      chk("retire_cnt", retire_cnt_o, m_cnt);
      if (q.size() > 0) begin
        chk("wb_wreg", wb_wreg_o, q[0].wreg);
        chk("wb_addr", wb_addr_o, q[0].addr);
        chk("wb_data", wb_data_o, q[0].data);
      end else begin
        chk("wb_wreg_idle", wb_wreg_o, '0);
      end
`ifdef MEMWB_FWD_EN
      chk("fwd", {fwd_hit_o, fwd_data_o}, fwd_model(fwd_addr_i));
`endif
    end
  end

  // One clock: advance the model with the inputs present at the edge, then leave the edge
  task automatic cycle();
    bit acc;
    bit emi;
    @(posedge clk);
    if (rst_n) begin
      acc = in_valid_i && (q.size() < 2);
      emi = (q.size() > 0) && out_ready_i;
      if (emi) m_cnt = m_cnt + 32'd1;
      if (flush_i) q.delete();
      else begin
        if (emi) void'(q.pop_front());
        if (acc) q.push_back(cond(in_wreg_i, in_addr_i, in_data_i));
      end
    end
    #1;
  endtask

  task automatic set_beat(input logic [LANES-1:0] w, input logic [LANES*ADDR_W-1:0] a,
                          input logic [LANES*DATA_W-1:0] d);
    in_valid_i = 1'b1;
    in_wreg_i  = w;
    in_addr_i  = a;
    in_data_i  = d;
  endtask

  task automatic drive_rand();
    in_valid_i  = ($urandom_range(0, 3) != 0);
    out_ready_i = ($urandom_range(0, 2) != 0);
    flush_i     = ($urandom_range(0, 29) == 0);
    for (int k = 0; k < LANES; k++) begin
      in_wreg_i[k] = $urandom_range(0, 3) != 0;
      in_addr_i[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3))
                                                                   : ADDR_W'($urandom_range(0, 31));
      in_data_i[k*DATA_W +: DATA_W] = $urandom;
    end
`ifdef MEMWB_FWD_EN
    fwd_addr_i = ADDR_W'($urandom_range(0, 4));
`endif
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_wreg", wb_wreg_o, '0);
    chk("rst_addr", wb_addr_o, '0);
    chk("rst_data", wb_data_o, '0);
    chk("rst_cnt", retire_cnt_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Single beat: lane0 writes x5
    out_ready_i = 1'b1;
    set_beat(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEAD_BEEF});
    cycle();
    in_valid_i = 1'b0;
    chk("single_valid", out_valid_o, 1'b1);
    chk("single_wreg", wb_wreg_o, 3'b001);
    chk("single_addr", wb_addr_o[4:0], 5'd5);
    chk("single_data", wb_data_o[31:0], 32'hDEAD_BEEF);
    cycle();
    chk("single_cnt", retire_cnt_o, 32'd1);

    // Back-pressure: A in main, B in skid
    out_ready_i = 1'b0;
    set_beat(3'b001, {5'd0, 5'd0, 5'd1}, {32'h0, 32'h0, 32'hAAAA});
    cycle();
    set_beat(3'b001, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'hBBBB});
    cycle();
    in_valid_i = 1'b0;
    chk("bp_ready_low", in_ready_o, 1'b0);
    chk("bp_hold_a", wb_data_o[31:0], 32'hAAAA);
    out_ready_i = 1'b1;
    cycle();
    chk("bp_then_b", wb_data_o[31:0], 32'hBBBB);
    chk("bp_ready_back", in_ready_o, 1'b1);
    cycle();
    chk("bp_drained", out_valid_o, 1'b0);
    chk("bp_cnt", retire_cnt_o, 32'd3);

    // Flush with both slots full and a beat offered
    out_ready_i = 1'b0;
    set_beat(3'b001, {5'd0, 5'd0, 5'd1}, {32'h0, 32'h0, 32'h1111});
    cycle();
    set_beat(3'b001, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h2222});
    cycle();
    set_beat(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'hCCCC});
    flush_i = 1'b1;
    cycle();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_ready", in_ready_o, 1'b1);
    out_ready_i = 1'b1;
    cycle();
    chk("flush_dropped", out_valid_o, 1'b0);
    chk("flush_cnt", retire_cnt_o, 32'd3);

    // Same-beat conflict and x0 suppression
    set_beat(3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h22, 32'h11});
    cycle();
    set_beat(3'b111, {5'd4, 5'd9, 5'd0}, {32'h3, 32'h2, 32'h1});
    chk("conflict_wreg", wb_wreg_o, 3'b010);
    chk("conflict_data", wb_data_o[63:32], 32'h22);
    cycle();
    in_valid_i = 1'b0;
    chk("x0_wreg", wb_wreg_o, 3'b110);
    cycle();

`ifdef MEMWB_FWD_EN
    // Forwarding: skid copy of x3 is younger than main copy
    out_ready_i = 1'b0;
    set_beat(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h10});
    cycle();
    set_beat(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h20});
    cycle();
    in_valid_i = 1'b0;
    fwd_addr_i = 5'd3;
    #1;
    chk("fwd_hit", fwd_hit_o, 1'b1);
    chk("fwd_data", fwd_data_o, 32'h20);
    fwd_addr_i = 5'd0;
    #1;
    chk("fwd_x0", fwd_hit_o, 1'b0);
    out_ready_i = 1'b1;
    cycle();
    cycle();
`endif

    // Counter wrap
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    out_ready_i = 1'b1;
    set_beat(3'b000, '0, '0);
    cycle();
    in_valid_i = 1'b0;
    cycle();
    chk("cnt_wrap", retire_cnt_o, 32'd0);

    // Randomized traffic with one asynchronous reset mid-stream
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 1'b0;
        q.delete();
        m_cnt = '0;
        #1;
        chk("midrst_valid", out_valid_o, 1'b0);
        chk("midrst_ready", in_ready_o, 1'b1);
        chk("midrst_cnt", retire_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      drive_rand();
      cycle();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
